cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 115 +++++++++++
 tb/tb_cache_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port (instruction/data) cache line arbiter onto a single line memory
// Requests are granted from S_IDLE only; contention is resolved away from the last served port.

module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    output logic              data_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INSTR = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   last_grant_next;
    logic   d_req;

    assign d_req = d_read | d_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;

        case (state)
            S_IDLE: begin
                // last_grant==0 means the instruction port was served last, so data wins a tie
                if (i_read && d_req) begin
                    state_next = last_grant ? S_INSTR : S_DATA;
                end else if (i_read) begin
                    state_next = S_INSTR;
                end else if (d_req) begin
                    state_next = S_DATA;
                end
            end

            S_INSTR: begin
                mem_read = i_read;
                mem_addr = i_addr;
                i_resp   = mem_resp;
                if (mem_resp) begin
                    state_next      = S_IDLE;
                    last_grant_next = 1'b0;
                end else if (!i_read) begin
                    state_next = S_IDLE;
                end
            end

            S_DATA: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_resp    = mem_resp;
                if (mem_resp) begin
                    state_next      = S_IDLE;
                    last_grant_next = 1'b1;
                end else if (!d_req) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign i_rdata    = mem_rdata;
    assign d_rdata    = mem_rdata;
    assign data_state = (state == S_DATA);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed vector table, corner sequences and randomized model check for cache_arbiter

module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam int OW = 5 + AW + LW + 2;
    localparam logic [AW-1:0] I_ADDR = 32'h0000_1040;
    localparam logic [AW-1:0] D_ADDR = 32'h0000_2080;
    localparam logic [LW-1:0] PAT_B  = {8{32'hB0B0_5A5A}};

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          data_state;

    int n_tests;
    int n_fail;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .data_state(data_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st: 0 idle, 1 instruction grant, 2 data grant
    typedef struct {
        bit       ir, dr, dw, wb, mr;
        bit [1:0] st;
        bit       mrd, mwr, iro, dro;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(bit ir, bit dr, bit dw, bit wb, bit mr,
                                bit [1:0] st, bit mrd, bit mwr, bit iro, bit dro);
        row_t r;
        r.ir = ir; r.dr = dr; r.dw = dw; r.wb = wb; r.mr = mr;
        r.st = st; r.mrd = mrd; r.mwr = mwr; r.iro = iro; r.dro = dro;
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [OW-1:0] obs();
        return {mem_read, mem_write, i_resp, d_resp, data_state, mem_addr, mem_wdata,
                i_rdata == mem_rdata, d_rdata == mem_rdata};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drives one cycle from the current point (just after a rising edge) and checks mid-cycle.
    task automatic apply(input row_t r, input string name);
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;
        i_read    = r.ir;
        d_read    = r.dr;
        d_write   = r.dw;
        d_wdata   = r.wb ? PAT_B : '0;
        mem_resp  = r.mr;
        i_addr    = I_ADDR;
        d_addr    = D_ADDR;
        mem_rdata = rand_line();
        ea = (r.st == 2'd1) ? I_ADDR : (r.st == 2'd2) ? D_ADDR : '0;
        ew = (r.st == 2'd2) ? d_wdata : '0;
        @(negedge clk);
        chk(name, obs(), {r.mrd, r.mwr, r.iro, r.dro, r.st == 2'd2, ea, ew, 2'b11});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model state: who holds the memory, and whether data was the last port served.
    int owner;
    bit served_data;

    initial begin
        logic          e_mrd, e_mwr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        logic          m_iresp, m_dresp;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        i_read = 1'b1; d_read = 1'b0; d_write = 1'b1; mem_resp = 1'b1;
        i_addr = I_ADDR; d_addr = D_ADDR; d_wdata = PAT_B; mem_rdata = rand_line();
        #2;
        chk("reset_state", obs(), {5'b0, {AW{1'b0}}, {LW{1'b0}}, 2'b11});
        i_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // contention right after reset: data first, then instruction
        tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 2, 1,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 2, 1,0,0,1));
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 1, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0, 0,0,0,0));
        // single instruction read, response 3 cycles after mem_read rises
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 1, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0, 0,0,0,0));
        // stray response while idle
        tbl.push_back(mk(0,0,0,0,1, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0, 0,0,0,0));
        // data read leaves last_grant=data, then an aborted instruction read must not change it
        tbl.push_back(mk(0,1,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 2, 1,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 2, 1,0,0,1));
        tbl.push_back(mk(1,0,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1, 1,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 1, 1,0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 2, 1,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 2, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // write-back then fill while an instruction read waits
        apply(mk(0,0,1,1,0, 0, 0,0,0,0), "wb_arb");
        apply(mk(1,0,1,1,0, 2, 0,1,0,0), "wb_grant");
        apply(mk(1,0,1,1,0, 2, 0,1,0,0), "wb_hold");
        apply(mk(1,0,1,1,1, 2, 0,1,0,1), "wb_resp");
        apply(mk(1,1,0,0,0, 0, 0,0,0,0), "fill_rearb");
        apply(mk(1,1,0,0,0, 1, 1,0,0,0), "fill_instr_first");
        apply(mk(1,1,0,0,1, 1, 1,0,1,0), "fill_instr_resp");
        apply(mk(0,1,0,0,0, 0, 0,0,0,0), "fill_arb");
        apply(mk(0,1,0,0,0, 2, 1,0,0,0), "fill_grant");
        apply(mk(0,1,0,0,1, 2, 1,0,0,1), "fill_resp");
        apply(mk(0,0,0,0,0, 0, 0,0,0,0), "fill_done");

        // reset two cycles into a write grant
        apply(mk(0,0,1,1,0, 0, 0,0,0,0), "rst_arb");
        apply(mk(0,0,1,1,0, 2, 0,1,0,0), "rst_data1");
        apply(mk(0,0,1,1,0, 2, 0,1,0,0), "rst_data2");
        rst = 1'b0;
        #1;
        chk("rst_mid_transfer", obs(), {5'b0, {AW{1'b0}}, {LW{1'b0}}, 2'b11});
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk(0,0,1,1,0, 0, 0,0,0,0), "rst_rearb");
        apply(mk(0,0,1,1,0, 2, 0,1,0,0), "rst_regrant");
        apply(mk(0,0,1,1,1, 2, 0,1,0,1), "rst_complete");
        apply(mk(0,0,0,0,0, 0, 0,0,0,0), "rst_done");

        // randomized traffic against the reference model
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        do_reset();
        owner = 0;
        served_data = 1'b0;
        m_iresp = 1'b0;
        m_dresp = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (i_read) begin
                if (m_iresp || $urandom_range(0, 19) == 0) i_read = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_addr = $urandom;
            end
            if (d_read || d_write) begin
                if (m_dresp || $urandom_range(0, 19) == 0) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_write = 1'b1;
                else d_read = 1'b1;
                d_addr  = $urandom;
                d_wdata = rand_line();
            end
            mem_resp  = ($urandom_range(0, 3) == 0);
            mem_rdata = rand_line();

            e_mrd = 1'b0; e_mwr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
            e_addr = '0; e_wdata = '0;
            if (owner == 1) begin
                e_mrd = i_read; e_addr = i_addr; e_ir = mem_resp;
            end else if (owner == 2) begin
                e_mrd = d_read; e_mwr = d_write; e_addr = d_addr; e_wdata = d_wdata;
                e_dr = mem_resp;
            end
            m_iresp = e_ir;
            m_dresp = e_dr;

            @(negedge clk);
            chk($sformatf("rand%0d", c), obs(),
                {e_mrd, e_mwr, e_ir, e_dr, owner == 2, e_addr, e_wdata, 2'b11});
            @(posedge clk);

            if (owner == 0) begin
                if (i_read && (d_read || d_write)) owner = served_data ? 1 : 2;
                else if (i_read) owner = 1;
                else if (d_read || d_write) owner = 2;
            end else if (mem_resp) begin
                served_data = (owner == 2);
                owner = 0;
            end else if ((owner == 1 && !i_read) || (owner == 2 && !(d_read || d_write))) begin
                owner = 0;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
